// File: rtl/eth_txframe_sched_pkg.sv
// Shared types for the two-requester transmit frame scheduler:
// FSM state encoding and the completion status codes returned with Ack.
package eth_txframe_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_WSTAT = 3'd5,
    S_RETRY = 3'd6,
    S_ZERO  = 3'd7
  } sched_state_e;

  localparam logic [1:0] ST_DONE  = 2'b00;
  localparam logic [1:0] ST_ABORT = 2'b01;
  localparam logic [1:0] ST_UNDR  = 2'b10;
  localparam logic [1:0] ST_ZERO  = 2'b11;

  // A MAC abort is reported as an underrun when the source had signalled one.
  function automatic logic [1:0] abort_status(input logic undr);
    if (undr) begin
      return ST_UNDR;
    end else begin
      return ST_ABORT;
    end
  endfunction

endpackage

// File: rtl/eth_txframe_sched_arb.sv
// Two-way request arbiter: fixed priority to requester 1, or round-robin
// where ptr names the requester preferred on a tie.
module eth_txframe_sched_arb #(
  parameter int CTRL_PRIO = 1
) (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic grant,
  output logic valid
);

  // Grant selection; a lone request always wins.
  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      grant = (CTRL_PRIO != 0) ? 1'b1 : ptr;
    end else begin
      grant = req1;
    end
  end

endmodule

// File: rtl/eth_txframe_sched.sv
// Schedules frames from two requesters onto the MAC transmit datapath,
// streams bytes by random-access read, handles retry/abort/underrun and reports completion.
module eth_txframe_sched
  import eth_txframe_sched_pkg::*;
#(
  parameter int AW        = 11,
  parameter int CTRL_PRIO = 1
) (
  input  logic          MTxClk,
  input  logic          Reset,
  input  logic          Req0,
  input  logic          Req1,
  input  logic [AW-1:0] Len0,
  input  logic [AW-1:0] Len1,
  input  logic          SrcErr0,
  input  logic          SrcErr1,
  output logic [AW-1:0] RdAddr,
  output logic          RdSel,
  input  logic [7:0]    RdData0,
  input  logic [7:0]    RdData1,
  output logic          TxStartFrm,
  output logic          TxEndFrm,
  output logic          TxUnderRun,
  output logic [7:0]    TxData,
  input  logic          TxUsedData,
  input  logic          TxDone,
  input  logic          TxRetry,
  input  logic          TxAbort,
  input  logic [3:0]    RetryCnt,
  output logic          Ack0,
  output logic          Ack1,
  output logic [1:0]    Status,
  output logic [3:0]    StatRetry
);

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  sched_state_e  state;
  logic [AW-1:0] lenq;
  logic [AW-1:0] idx;
  logic          rr_ptr;
  logic          done_q;
  logic          retry_q;
  logic          abort_q;

  logic          grant;
  logic          grant_valid;
  logic [AW-1:0] grant_len;
  logic [AW-1:0] last_idx;
  logic [7:0]    rd_byte;
  logic          src_err;
  logic          done_rise;
  logic          retry_rise;
  logic          abort_rise;
  logic          fin;
  logic [1:0]    fin_code;
  logic          go_retry;

  eth_txframe_sched_arb #(.CTRL_PRIO(CTRL_PRIO)) u_arb (
    .req0  (Req0),
    .req1  (Req1),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  assign grant_len  = grant ? Len1 : Len0;
  assign last_idx   = lenq - ADDR_ONE;
  assign rd_byte    = RdSel ? RdData1 : RdData0;
  assign src_err    = RdSel ? SrcErr1 : SrcErr0;
  assign done_rise  = TxDone  & ~done_q;
  assign retry_rise = TxRetry & ~retry_q;
  assign abort_rise = TxAbort & ~abort_q;

  // Frame-ending decision with abort > retry > done precedence.
  always_comb begin
    fin      = 1'b0;
    fin_code = ST_DONE;
    go_retry = 1'b0;
    case (state)
      S_START, S_DATA, S_WSTAT: begin
        if (abort_rise) begin
          fin      = 1'b1;
          fin_code = abort_status(TxUnderRun);
        end else if (retry_rise) begin
          go_retry = 1'b1;
        end else if (done_rise) begin
          fin      = 1'b1;
          fin_code = ST_DONE;
        end else begin
          fin = 1'b0;
        end
      end
      S_ZERO: begin
        fin      = 1'b1;
        fin_code = ST_ZERO;
      end
      default: begin
        fin = 1'b0;
      end
    endcase
  end

  // Scheduler FSM. RdAddr runs one byte ahead of TxData so the next byte is
  // already on RdData when TxUsedData arrives; it parks at 0 outside a frame.
  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      lenq       <= '0;
      idx        <= '0;
      rr_ptr     <= 1'b0;
      done_q     <= 1'b0;
      retry_q    <= 1'b0;
      abort_q    <= 1'b0;
      RdAddr     <= '0;
      RdSel      <= 1'b0;
      TxStartFrm <= 1'b0;
      TxEndFrm   <= 1'b0;
      TxUnderRun <= 1'b0;
      TxData     <= 8'h00;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      Status     <= 2'b00;
      StatRetry  <= 4'h0;
    end else begin
      done_q  <= TxDone;
      retry_q <= TxRetry;
      abort_q <= TxAbort;
      Ack0    <= 1'b0;
      Ack1    <= 1'b0;
      if (fin) begin
        Ack0       <= ~RdSel;
        Ack1       <= RdSel;
        Status     <= fin_code;
        StatRetry  <= RetryCnt;
        RdAddr     <= '0;
        TxStartFrm <= 1'b0;
        TxEndFrm   <= 1'b0;
        TxUnderRun <= 1'b0;
        state      <= S_IDLE;
      end else if (go_retry) begin
        RdAddr     <= '0;
        TxStartFrm <= 1'b0;
        TxEndFrm   <= 1'b0;
        TxUnderRun <= 1'b0;
        state      <= S_RETRY;
      end else begin
        case (state)
          S_IDLE: begin
            // The Ack cycle never arbitrates, so the served request can drop first.
            if (grant_valid && !Ack0 && !Ack1) begin
              state <= S_ARB;
            end else begin
              state <= S_IDLE;
            end
          end
          S_ARB: begin
            if (grant_valid) begin
              RdSel  <= grant;
              lenq   <= grant_len;
              rr_ptr <= ~grant;
              state  <= (grant_len == '0) ? S_ZERO : S_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end
          S_LOAD: begin
            TxData     <= rd_byte;
            TxStartFrm <= 1'b1;
            TxEndFrm   <= (lenq == ADDR_ONE);
            idx        <= '0;
            RdAddr     <= (lenq == ADDR_ONE) ? '0 : ADDR_ONE;
            state      <= S_START;
          end
          S_START, S_DATA: begin
            if ((state == S_DATA) && src_err) begin
              TxUnderRun <= 1'b1;
              TxEndFrm   <= 1'b0;
              state      <= S_WSTAT;
            end else if (TxUsedData) begin
              TxStartFrm <= 1'b0;
              if (idx == last_idx) begin
                TxEndFrm <= 1'b0;
                state    <= S_WSTAT;
              end else begin
                idx      <= idx + ADDR_ONE;
                TxData   <= rd_byte;
                TxEndFrm <= ((idx + ADDR_ONE) == last_idx);
                if (RdAddr != last_idx) begin
                  RdAddr <= RdAddr + ADDR_ONE;
                end else begin
                  RdAddr <= RdAddr;
                end
                state <= S_DATA;
              end
            end else begin
              state <= state;
            end
          end
          S_WSTAT: begin
            state <= S_WSTAT;
          end
          S_RETRY: begin
            state <= S_LOAD;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
